// File: rtl/img2col_row_serializer_pkg.sv
// Shared types and sizing for the img2col row serializer.
// Optional feature macro: SER_LEN_EN (run-time row length, see clamp_len).
package img2col_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int REG_NUM    = 20;
    localparam int IDX_W      = $clog2(REG_NUM);
    localparam int LEN_W      = $clog2(REG_NUM + 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

    // A zero-length request still emits one word so every row carries a last beat.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
        if (req == '0) begin
            return LEN_W'(1);
        end
        if (req > LEN_W'(REG_NUM)) begin
            return LEN_W'(REG_NUM);
        end
        return req;
    endfunction

endpackage

// File: rtl/img2col_row_serializer_if.sv
// Row-load and word-stream handshake bundle for the img2col row serializer.
// Optional feature macro: SER_LEN_EN (adds row_len).
interface img2col_ser_if;
    import img2col_pkg::*;

    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // a source holding valid keeps its payload stable until that transfer.
    logic                  in_valid;
    logic                  in_ready;
    word_t                 in_row [REG_NUM];
`ifdef SER_LEN_EN
    logic [LEN_W-1:0]      row_len;
`endif
    logic                  out_valid;
    logic                  out_ready;
    word_t                 out_data;
    logic                  out_last;
    logic [IDX_W-1:0]      out_idx;

    modport slave (
`ifdef SER_LEN_EN
        input  row_len,
`endif
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_data, out_last, out_idx
    );

    modport master (
`ifdef SER_LEN_EN
        output row_len,
`endif
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_idx
    );

endinterface

// File: rtl/img2col_row_serializer.sv
// Parallel-in / serial-out drain of one img2col row, one word per beat, no bubbles between rows.
// Optional feature macro: SER_LEN_EN (row length taken from row_len instead of REG_NUM).
module img2col_row_serializer
    import img2col_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    img2col_ser_if.slave  bus,
    output ser_state_t    state_o
);

    ser_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    word_t             buf_q [REG_NUM];

    logic              out_valid;
    logic              out_last;
    logic              in_ready;
    logic              load;
    word_t             out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= LEN_W'(REG_NUM);
            for (int i = 0; i < REG_NUM; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            if (load) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    buf_q[i] <= bus.in_row[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        if (load) begin
`ifdef SER_LEN_EN
            len_d = clamp_len(bus.row_len);
`else
            len_d = LEN_W'(REG_NUM);
`endif
        end
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_SHIFT;
                    idx_d   = '0;
                end
            end
            S_SHIFT: begin
                if (bus.out_ready) begin
                    if (!out_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (load) begin
                        // Final beat and next load share a cycle: zero-bubble row turnover.
                        idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_SHIFT);
        out_last  = out_valid && (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
        out_data  = out_valid ? buf_q[idx_q] : '0;
        in_ready  = !out_valid || (bus.out_ready && out_last);
        load      = bus.in_valid && in_ready;
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_data;
    assign bus.out_idx   = idx_q;
    assign bus.in_ready  = in_ready;
    assign state_o       = state_q;

endmodule
